// File: rtl/main_memory_pkg.sv
// Shared definitions for the wait-state main memory.
// Holds the FSM state encoding, default geometry constants and a
// ceiling-log2 helper used to size the index and byte-select fields.
package main_memory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam int DEF_DATAWIDTH_BUS = 32;
  localparam int DEF_ADDRWIDTH_BUS = 32;
  localparam int DEF_DEPTH_WORDS   = 1024;
  localparam int DEF_WAIT_STATES   = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/main_memory_ws_array.sv
// Single-port synchronous RAM, DEPTH_WORDS x DATAWIDTH_BUS.
// Ports:
//   clk     - rising-edge clock
//   wr_en   - write wr_data into word idx
//   rd_en   - capture word idx into the read register
//   idx     - word index
//   wr_data - write data
//   rd_data - registered read data (holds until the next rd_en)
// No reset on storage or the read register so the array maps onto block RAM.
module main_memory_ws_array #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int DEPTH_WORDS   = 1024,
  parameter int IDX_W         = 10
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [IDX_W-1:0]         idx,
  input  logic [DATAWIDTH_BUS-1:0] wr_data,
  output logic [DATAWIDTH_BUS-1:0] rd_data
);

  logic [DATAWIDTH_BUS-1:0] mem_q [DEPTH_WORDS];
  logic [DATAWIDTH_BUS-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[idx];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/main_memory_ws.sv
// Word-organised main memory with byte addressing, configurable wait states,
// a one-cycle ACK and an ERR qualifier for misaligned/out-of-range accesses.
// Ports:
//   MAIN_MEMORY_WS_CLOCK_50           - clock, rising edge
//   MAIN_MEMORY_WS_RESET_InLow        - asynchronous active-low reset
//   MAIN_MEMORY_WS_data_InBUS         - write data
//   MAIN_MEMORY_WS_ADDRESS_data_InBUS - byte address
//   MAIN_MEMORY_WS_RD_data_In         - read request, held until ACK
//   MAIN_MEMORY_WS_WR_data_In         - write request, held until ACK
//   MAIN_MEMORY_WS_data_OutBUS        - read data, holds until next read commit
//   MAIN_MEMORY_WS_ACK                - one-cycle completion pulse
//   MAIN_MEMORY_WS_ERR                - error qualifier, valid with ACK
//   MAIN_MEMORY_WS_BUSY               - high while in WAIT or ACK
module main_memory_ws
  import main_memory_pkg::*;
#(
  parameter int DATAWIDTH_BUS = DEF_DATAWIDTH_BUS,
  parameter int ADDRWIDTH_BUS = DEF_ADDRWIDTH_BUS,
  parameter int DEPTH_WORDS   = DEF_DEPTH_WORDS,
  parameter int WAIT_STATES   = DEF_WAIT_STATES,
  parameter logic [ADDRWIDTH_BUS-1:0] BASE_ADDR = '0
) (
  input  logic                     MAIN_MEMORY_WS_CLOCK_50,
  input  logic                     MAIN_MEMORY_WS_RESET_InLow,
  input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_WS_data_InBUS,
  input  logic [ADDRWIDTH_BUS-1:0] MAIN_MEMORY_WS_ADDRESS_data_InBUS,
  input  logic                     MAIN_MEMORY_WS_RD_data_In,
  input  logic                     MAIN_MEMORY_WS_WR_data_In,
  output logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_WS_data_OutBUS,
  output logic                     MAIN_MEMORY_WS_ACK,
  output logic                     MAIN_MEMORY_WS_ERR,
  output logic                     MAIN_MEMORY_WS_BUSY
);

  localparam int BYTE_SEL_W = clog2(DATAWIDTH_BUS / 8);
  localparam int IDX_W      = clog2(DEPTH_WORDS);
  localparam logic [ADDRWIDTH_BUS-1:0] LOW_MASK =
    ADDRWIDTH_BUS'((64'd1 << BYTE_SEL_W) - 64'd1);
  localparam logic [ADDRWIDTH_BUS-1:0] DEPTH_A = ADDRWIDTH_BUS'(DEPTH_WORDS);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic clk, rst_n, rd_in, wr_in;
  logic [ADDRWIDTH_BUS-1:0] addr_in;
  logic [DATAWIDTH_BUS-1:0] data_in;

  assign clk     = MAIN_MEMORY_WS_CLOCK_50;
  assign rst_n   = MAIN_MEMORY_WS_RESET_InLow;
  assign rd_in   = MAIN_MEMORY_WS_RD_data_In;
  assign wr_in   = MAIN_MEMORY_WS_WR_data_In;
  assign addr_in = MAIN_MEMORY_WS_ADDRESS_data_InBUS;
  assign data_in = MAIN_MEMORY_WS_data_InBUS;

  // Address decode. Simultaneous RD+WR is folded into the error flag.
  logic [ADDRWIDTH_BUS-1:0] offset, word_full;
  logic [IDX_W-1:0]         dec_idx;
  logic                     dec_err;

  always_comb begin
    offset    = addr_in - BASE_ADDR;
    word_full = offset >> BYTE_SEL_W;
    dec_idx   = word_full[IDX_W-1:0];
    dec_err   = ((addr_in & LOW_MASK) != '0) || (addr_in < BASE_ADDR) ||
                (word_full >= DEPTH_A) || (rd_in && wr_in);
  end

  state_e                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [DATAWIDTH_BUS-1:0] data_q, data_d;
  logic                     wr_q, wr_d;
  logic                     err_q, err_d;
  logic                     out_vld_q, out_vld_d;

  // Commit controls: with zero wait states the commit happens on the accept
  // edge itself, so the live decode is used instead of the latched copy.
  logic                     commit, c_wr, c_err;
  logic [IDX_W-1:0]         c_idx;
  logic [DATAWIDTH_BUS-1:0] c_data;
  logic                     ram_we, ram_re;
  logic [DATAWIDTH_BUS-1:0] ram_rdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    wr_d      = wr_q;
    err_d     = err_q;
    out_vld_d = out_vld_q;
    commit    = 1'b0;
    c_idx     = idx_q;
    c_data    = data_q;
    c_wr      = wr_q;
    c_err     = err_q;

    case (state_q)
      IDLE: begin
        if (rd_in || wr_in) begin
          idx_d  = dec_idx;
          data_d = data_in;
          wr_d   = wr_in && !rd_in;
          err_d  = dec_err;
          cnt_d  = WS_LOAD;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
          end else begin
            state_d = ACK;
            commit  = 1'b1;
            c_idx   = dec_idx;
            c_data  = data_in;
            c_wr    = wr_in && !rd_in;
            c_err   = dec_err;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ACK;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ram_we = commit && c_wr && !c_err;
    ram_re = commit && !c_wr && !c_err;

    // Output is qualified by out_vld: cleared by an erroring commit,
    // set by a good read, left alone by a good write.
    if (commit) begin
      if (c_err)      out_vld_d = 1'b0;
      else if (!c_wr) out_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      out_vld_q <= out_vld_d;
    end
  end

  main_memory_ws_array #(
    .DATAWIDTH_BUS(DATAWIDTH_BUS),
    .DEPTH_WORDS  (DEPTH_WORDS),
    .IDX_W        (IDX_W)
  ) u_array (
    .clk    (clk),
    .wr_en  (ram_we),
    .rd_en  (ram_re),
    .idx    (c_idx),
    .wr_data(c_data),
    .rd_data(ram_rdata)
  );

  assign MAIN_MEMORY_WS_data_OutBUS = out_vld_q ? ram_rdata : '0;
  assign MAIN_MEMORY_WS_ACK         = (state_q == ACK);
  assign MAIN_MEMORY_WS_ERR         = (state_q == ACK) && err_q;
  assign MAIN_MEMORY_WS_BUSY        = (state_q != IDLE);

endmodule

// File: tb/tb_main_memory_ws.sv
module tb_main_memory_ws;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // dut2: WAIT_STATES=2, dut0: WAIT_STATES=0
  logic [31:0] d2_data, d2_addr, d2_q;
  logic        d2_rd, d2_wr, d2_ack, d2_err, d2_busy;
  logic [31:0] d0_data, d0_addr, d0_q;
  logic        d0_rd, d0_wr, d0_ack, d0_err, d0_busy;

  main_memory_ws #(.WAIT_STATES(2)) dut2 (
    .MAIN_MEMORY_WS_CLOCK_50          (clk),
    .MAIN_MEMORY_WS_RESET_InLow       (rst_n),
    .MAIN_MEMORY_WS_data_InBUS        (d2_data),
    .MAIN_MEMORY_WS_ADDRESS_data_InBUS(d2_addr),
    .MAIN_MEMORY_WS_RD_data_In        (d2_rd),
    .MAIN_MEMORY_WS_WR_data_In        (d2_wr),
    .MAIN_MEMORY_WS_data_OutBUS       (d2_q),
    .MAIN_MEMORY_WS_ACK               (d2_ack),
    .MAIN_MEMORY_WS_ERR               (d2_err),
    .MAIN_MEMORY_WS_BUSY              (d2_busy)
  );

  main_memory_ws #(.WAIT_STATES(0)) dut0 (
    .MAIN_MEMORY_WS_CLOCK_50          (clk),
    .MAIN_MEMORY_WS_RESET_InLow       (rst_n),
    .MAIN_MEMORY_WS_data_InBUS        (d0_data),
    .MAIN_MEMORY_WS_ADDRESS_data_InBUS(d0_addr),
    .MAIN_MEMORY_WS_RD_data_In        (d0_rd),
    .MAIN_MEMORY_WS_WR_data_In        (d0_wr),
    .MAIN_MEMORY_WS_data_OutBUS       (d0_q),
    .MAIN_MEMORY_WS_ACK               (d0_ack),
    .MAIN_MEMORY_WS_ERR               (d0_err),
    .MAIN_MEMORY_WS_BUSY              (d0_busy)
  );

  int passes = 0;
  int fails  = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] data);
    if (sel) begin
      d2_rd = rd; d2_wr = wr; d2_addr = addr; d2_data = data;
    end else begin
      d0_rd = rd; d0_wr = wr; d0_addr = addr; d0_data = data;
    end
  endtask

  function automatic logic get_ack(input bit sel);
    return sel ? d2_ack : d0_ack;
  endfunction

  // One transaction: drive at negedge, accept on the following posedge,
  // count cycles until ACK is seen (bounded), capture ERR/data, release.
  task automatic txn(input bit sel, input bit rd, input bit wr,
                     input logic [31:0] addr, input logic [31:0] data,
                     input bit alt, input logic [31:0] alt_addr, input logic [31:0] alt_data,
                     output int lat, output logic err, output logic [31:0] q);
    @(negedge clk);
    drive(sel, rd, wr, addr, data);
    @(posedge clk);
    lat = 1;
    if (alt) begin
      #1;
      drive(sel, rd, wr, alt_addr, alt_data);
    end
    @(negedge clk);
    while (!get_ack(sel) && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    err = sel ? d2_err : d0_err;
    q   = sel ? d2_q : d0_q;
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
  endtask

  task automatic wr_chk(input bit sel, input logic [31:0] addr, input logic [31:0] data,
                        input int exp_lat, input logic exp_err, input string tag);
    int lat; logic err; logic [31:0] q;
    txn(sel, 1'b0, 1'b1, addr, data, 1'b0, 32'h0, 32'h0, lat, err, q);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
  endtask

  task automatic rd_chk(input bit sel, input logic [31:0] addr, input int exp_lat,
                        input logic exp_err, input logic [31:0] exp_q, input string tag);
    int lat; logic err; logic [31:0] q;
    txn(sel, 1'b1, 1'b0, addr, 32'h0, 1'b0, 32'h0, 32'h0, lat, err, q);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check({tag, "_data"}, q, exp_q);
  endtask

  initial begin
    int lat; logic err; logic [31:0] q;
    logic [7:0] ackvec;

    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack",  {31'd0, d2_ack},  32'd0);
    check("rst_err",  {31'd0, d2_err},  32'd0);
    check("rst_busy", {31'd0, d2_busy}, 32'd0);
    check("rst_data", d2_q, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write then read, 2 wait states -> ACK 3 cycles after accept
    txn(1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, lat, err, q);
    check("wr10_lat", lat, 3);
    check("wr10_err", {31'd0, err}, 32'd0);
    check("wr10_out_unchanged", q, 32'd0);
    rd_chk(1'b1, 32'h10, 3, 1'b0, 32'hDEADBEEF, "rd10");

    // Misaligned read
    rd_chk(1'b1, 32'h6, 3, 1'b1, 32'h0, "rd6_misaligned");

    // Out-of-range write leaves memory untouched
    wr_chk(1'b1, 32'h0, 32'h11111111, 3, 1'b0, "wr0");
    wr_chk(1'b1, 32'h1000, 32'hAAAAAAAA, 3, 1'b1, "wr1000_oor");
    rd_chk(1'b1, 32'h0, 3, 1'b0, 32'h11111111, "rd0_after_oor");

    // RD+WR together: error, no write
    wr_chk(1'b1, 32'h20, 32'h22222222, 3, 1'b0, "wr20");
    txn(1'b1, 1'b1, 1'b1, 32'h20, 32'hBAD0BAD0, 1'b0, 32'h0, 32'h0, lat, err, q);
    check("rdwr20_err", {31'd0, err}, 32'd1);
    check("rdwr20_data", q, 32'd0);
    rd_chk(1'b1, 32'h20, 3, 1'b0, 32'h22222222, "rd20_kept");

    // Address/data change during WAIT must not affect the transaction
    wr_chk(1'b1, 32'h50, 32'h50505050, 3, 1'b0, "wr50");
    txn(1'b1, 1'b0, 1'b1, 32'h40, 32'h44444444, 1'b1, 32'h50, 32'hFFFF0000, lat, err, q);
    check("wr40_alt_err", {31'd0, err}, 32'd0);
    rd_chk(1'b1, 32'h40, 3, 1'b0, 32'h44444444, "rd40_latched");
    rd_chk(1'b1, 32'h50, 3, 1'b0, 32'h50505050, "rd50_untouched");

    // Zero wait states: ACK one cycle after accept, back-to-back every 2 cycles
    wr_chk(1'b0, 32'h0, 32'h12345678, 1, 1'b0, "z_wr0");
    rd_chk(1'b0, 32'h0, 1, 1'b0, 32'h12345678, "z_rd0");
    rd_chk(1'b0, 32'h2, 1, 1'b1, 32'h0, "z_rd2_misaligned");
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    ackvec = 8'h0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      ackvec[i] = d0_ack;
      if (d0_ack) check("z_b2b_data", d0_q, 32'h12345678);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("z_b2b_ack_pattern", {24'd0, ackvec}, 32'h55);
    @(posedge clk);
    @(negedge clk);
    check("z_idle_busy", {31'd0, d0_busy}, 32'd0);

    // Async reset in the middle of a write's WAIT phase
    wr_chk(1'b1, 32'h30, 32'h33333333, 3, 1'b0, "wr30");
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h30, 32'h99999999);
    @(posedge clk);
    #2;
    check("ar_busy_before", {31'd0, d2_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_busy_drop", {31'd0, d2_busy}, 32'd0);
    check("ar_ack_drop",  {31'd0, d2_ack},  32'd0);
    check("ar_data_zero", d2_q, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk(1'b1, 32'h30, 3, 1'b0, 32'h33333333, "rd30_after_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
